fx_add_subt_unit: RTL and testbench
===================================

FX_ADD_SUBT_UNIT -- requirements
Module: fx_add_subt_unit

Interface
REQ-001 Parameter W, default 32: operand and result width in bits, two's complement; W SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 8: bits summed per compute cycle.
REQ-003 clk  input  1: system clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 beg_add_subt  input  1: start request from the CORDIC FSM.
REQ-006 ack_add_subt  input  1: FSM acknowledges that it has taken the result.
REQ-007 operation  input  1: 0 selects add (X+Y); 1 selects subtract (X-Y).
REQ-008 Data_X  input  W: first operand.
REQ-009 Data_Y  input  W: second operand.
REQ-010 ready_add_subt  output  1: registered; result valid and held.
REQ-011 Data_Result  output  W: registered sum or difference.
REQ-012 overflow_flag  output  1: registered; signed overflow of the last operation.

Function
REQ-013 The state machine SHALL have four states: IDLE, LOAD, CALC, DONE.
REQ-014 IDLE: beg_add_subt=1 at an edge SHALL move to LOAD; otherwise the state SHALL remain IDLE.
REQ-015 LOAD: Data_X, Data_Y and operation SHALL be captured at the edge that leaves LOAD; Y SHALL be inverted and carry-in set to 1 when operation=1, else carry-in=0; chunk counter=0; next state CALC.
REQ-016 CALC: each edge SHALL add chunk k of X and Y' plus the carry register, write result bits [k*CHUNK +: CHUNK] and update the carry; after chunk W/CHUNK-1 the next state SHALL be DONE.
REQ-017 Latency: with the defaults, ready_add_subt SHALL rise exactly 6 rising edges after the edge that samples beg_add_subt (1 LOAD + 4 CALC + 1 DONE entry); in general the latency SHALL be 2+W/CHUNK edges.
REQ-018 DONE: ready_add_subt=1; Data_Result and overflow_flag SHALL stay stable until ack_add_subt=1 is sampled, then the next state SHALL be IDLE and ready SHALL drop on that same edge.
REQ-019 overflow_flag SHALL equal the carry into the MSB XOR the carry out of the MSB, and SHALL be updated on the final CALC edge.
REQ-020 beg_add_subt in LOAD, CALC or DONE SHALL be ignored.
REQ-021 Operand changes after the LOAD edge SHALL NOT affect the result.
REQ-022 ack_add_subt outside DONE SHALL be ignored.
REQ-023 beg_add_subt and ack_add_subt both high in DONE: ack SHALL win and the state SHALL go to IDLE; beg SHALL only be re-sampled from IDLE on the following edge.
REQ-024 Back-to-back operation: beg held high through the ack edge SHALL start a new operation one edge after returning to IDLE.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, ready_add_subt=0, Data_Result=0, overflow_flag=0, and clear the carry and chunk counter, regardless of state, including mid-CALC.
REQ-026 reset SHALL take priority over beg_add_subt and ack_add_subt.

Configuration
REQ-027 Macro ADD_SUBT_SAT_EN defined: on overflow, Data_Result SHALL be clamped to the maximum positive value 0x7FFFFFFF when X is positive, or the minimum negative value 0x80000000 when X is negative; the clamp SHALL be applied on the DONE entry edge with no added latency; overflow_flag SHALL still be asserted.
REQ-028 Macro ADD_SUBT_SAT_EN undefined: Data_Result SHALL be the wrapped modulo-2^W result.

Structure
REQ-029 A shared package SHALL hold the state enumeration (IDLE, LOAD, CALC, DONE), the defaults for W and CHUNK, and the derived constant NUM_CHUNKS=W/CHUNK.
REQ-030 One sub-module, add_chunk, SHALL be used: a combinational CHUNK-bit adder with carry-in, carry-out and carry-into-MSB outputs, instantiated once and time-shared across CALC cycles.

Verification
REQ-031 Reset, then beg with X=0x00000005, Y=0x00000003, operation=0 -> ready rises 6 edges after beg; Result=0x00000008; overflow=0.
REQ-032 X=0x00000003, Y=0x00000005, operation=1 -> Result=0xFFFFFFFE; overflow=0; result held across 10 cycles without ack, then dropped the edge after ack.
REQ-033 X=0x7FFFFFFF, Y=0x00000001, operation=0 -> overflow=1; Result=0x80000000 without the macro, 0x7FFFFFFF with ADD_SUBT_SAT_EN.
REQ-034 X=0x000000FF, Y=0x00000001, operation=0 -> Result=0x00000100, checking carry across a chunk boundary; beg pulses during CALC have no effect on the result or timing.
REQ-035 Reset asserted on the 2nd CALC edge -> IDLE; all outputs 0 next cycle; a fresh beg then completes normally with the full latency.
REQ-036 beg and ack both high in DONE -> IDLE on that edge; new operation enters LOAD on the next edge; second result correct.

Source files
------------

// File: rtl/fx_add_subt_unit_pkg.sv
// Shared definitions for the chunked fixed-point add/subtract unit:
// FSM state encoding and default width constants.
package fx_add_subt_unit_pkg;

  localparam int W_DEF      = 32;
  localparam int CHUNK_DEF  = 8;
  localparam int NUM_CHUNKS = W_DEF / CHUNK_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fx_add_subt_unit_add_chunk.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB
// so the top can derive signed overflow on the most significant chunk.
module add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] low;

  always_comb begin
    low                   = {1'b0, a[CHUNK-2:0]} + {1'b0, b[CHUNK-2:0]} + {{(CHUNK-1){1'b0}}, cin};
    c_msb                 = low[CHUNK-1];
    {cout, sum[CHUNK-1]}  = {1'b0, a[CHUNK-1]} + {1'b0, b[CHUNK-1]} + {1'b0, c_msb};
    sum[CHUNK-2:0]        = low[CHUNK-2:0];
  end

endmodule

// File: rtl/fx_add_subt_unit.sv
// Multi-cycle two's complement add/subtract: one CHUNK-wide slice per cycle.
// Optional macro ADD_SUBT_SAT_EN clamps the result on signed overflow.
module fx_add_subt_unit
  import fx_add_subt_unit_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beg_add_subt,
  input  logic         ack_add_subt,
  input  logic         operation,
  input  logic [W-1:0] Data_X,
  input  logic [W-1:0] Data_Y,
  output logic         ready_add_subt,
  output logic [W-1:0] Data_Result,
  output logic         overflow_flag
);

  localparam int NCH   = W / CHUNK;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NCH - 1);

  state_t           state;
  logic [W-1:0]     x_reg;
  logic [W-1:0]     y_reg;
  logic [W-1:0]     sum_reg;
  logic             carry;
  logic [CNT_W-1:0] k;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_out;
  logic             c_msb;
  logic [W-1:0]     result_next;

  always_comb begin
    a_chunk = x_reg[k*CHUNK +: CHUNK];
    b_chunk = y_reg[k*CHUNK +: CHUNK];
  end

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a     (a_chunk),
    .b     (b_chunk),
    .cin   (carry),
    .sum   (s_chunk),
    .cout  (c_out),
    .c_msb (c_msb)
  );

  // Clamp direction follows the sign of X: overflow only happens when the
  // effective operands share X's sign.
  always_comb begin
`ifdef ADD_SUBT_SAT_EN
    if (overflow_flag)
      result_next = x_reg[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      result_next = sum_reg;
`else
    result_next = sum_reg;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ready_add_subt <= 1'b0;
      Data_Result    <= '0;
      overflow_flag  <= 1'b0;
      carry          <= 1'b0;
      k              <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      sum_reg        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (beg_add_subt) state <= LOAD;
        end
        LOAD: begin
          x_reg <= Data_X;
          y_reg <= operation ? ~Data_Y : Data_Y;
          carry <= operation;
          k     <= '0;
          state <= CALC;
        end
        CALC: begin
          sum_reg[k*CHUNK +: CHUNK] <= s_chunk;
          carry                     <= c_out;
          k                         <= k + 1'b1;
          if (k == LAST_K) begin
            overflow_flag <= c_msb ^ c_out;
            state         <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; ack is honoured once ready.
          if (!ready_add_subt) begin
            ready_add_subt <= 1'b1;
            Data_Result    <= result_next;
          end else if (ack_add_subt) begin
            ready_add_subt <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx_add_subt_unit.sv
// Directed bench for fx_add_subt_unit: driver tasks issue operations and push
// expected {overflow,result}; a negedge monitor pops and compares on ready rise.
module tb_fx_add_subt_unit;
  import fx_add_subt_unit_pkg::*;

  localparam int W = 32;
  localparam int LAT = 2 + NUM_CHUNKS;

  logic         clk;
  logic         reset;
  logic         beg_add_subt;
  logic         ack_add_subt;
  logic         operation;
  logic [W-1:0] Data_X;
  logic [W-1:0] Data_Y;
  logic         ready_add_subt;
  logic [W-1:0] Data_Result;
  logic         overflow_flag;

  logic [W:0] exp_q[$];
  int total;
  int bad;
  logic ready_q;

  fx_add_subt_unit dut (
    .clk            (clk),
    .reset          (reset),
    .beg_add_subt   (beg_add_subt),
    .ack_add_subt   (ack_add_subt),
    .operation      (operation),
    .Data_X         (Data_X),
    .Data_Y         (Data_Y),
    .ready_add_subt (ready_add_subt),
    .Data_Result    (Data_Result),
    .overflow_flag  (overflow_flag)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  initial ready_q = 1'b0;
  always @(negedge clk) begin
    logic [W:0] e;
    if (ready_add_subt === 1'b1 && ready_q !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_result", 64'(Data_Result), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", 64'(Data_Result), 64'(e[W-1:0]));
        check("sb_overflow", 64'(overflow_flag), 64'(e[W]));
      end
    end
    ready_q = ready_add_subt;
  end

  // Issue one operation, measure latency, optionally hold before ack.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                       input logic [W-1:0] exp_r, input logic exp_o,
                       input int hold, input bit pulses);
    int n;
    exp_q.push_back({exp_o, exp_r});
    @(negedge clk);
    Data_X = x; Data_Y = y; operation = op; beg_add_subt = 1'b1;
    @(posedge clk); #1;
    beg_add_subt = 1'b0;
    n = 0;
    while (ready_add_subt !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        Data_X = $urandom; Data_Y = $urandom; operation = 1'($urandom_range(0, 1));
      end
      if (pulses) beg_add_subt = (n == 2 || n == 3);
    end
    beg_add_subt = 1'b0;
    check("latency", 64'(n), 64'(LAT));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_ready", 64'(ready_add_subt), 64'd1);
      check("hold_result", 64'(Data_Result), 64'(exp_r));
    end
    @(negedge clk);
    ack_add_subt = 1'b1;
    @(posedge clk); #1;
    ack_add_subt = 1'b0;
    check("ready_drop_on_ack", 64'(ready_add_subt), 64'd0);
  endtask

  initial begin
    int n;
    total = 0; bad = 0;
    reset = 1'b1; beg_add_subt = 1'b0; ack_add_subt = 1'b0; operation = 1'b0;
    Data_X = '0; Data_Y = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_ready", 64'(ready_add_subt), 64'd0);
    check("reset_result", 64'(Data_Result), 64'd0);
    check("reset_overflow", 64'(overflow_flag), 64'd0);

    // ack outside DONE must be ignored
    @(negedge clk); ack_add_subt = 1'b1;
    @(posedge clk); #1 ack_add_subt = 1'b0;
    check("stray_ack_idle", 64'(ready_add_subt), 64'd0);

    do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 0, 1'b0);
    do_op(32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 10, 1'b0);
`ifdef ADD_SUBT_SAT_EN
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 2, 1'b0);
`else
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, 2, 1'b0);
`endif

    // reset on the second CALC edge aborts the operation
    @(negedge clk);
    Data_X = 32'h0000_1111; Data_Y = 32'h0000_2222; operation = 1'b0; beg_add_subt = 1'b1;
    @(posedge clk); #1 beg_add_subt = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midcalc_reset_ready", 64'(ready_add_subt), 64'd0);
    check("midcalc_reset_result", 64'(Data_Result), 64'd0);
    check("midcalc_reset_overflow", 64'(overflow_flag), 64'd0);
    repeat (8) @(posedge clk);
    #1 check("post_reset_idle", 64'(ready_add_subt), 64'd0);

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1, 1'b1);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 0, 1'b0);

    // beg and ack together in DONE: ack wins, beg restarts from IDLE next edge
    exp_q.push_back({1'b0, 32'h2345_6789});
    @(negedge clk);
    Data_X = 32'h1234_5678; Data_Y = 32'h1111_1111; operation = 1'b0; beg_add_subt = 1'b1;
    @(posedge clk); #1 beg_add_subt = 1'b0;
    n = 0;
    while (ready_add_subt !== 1'b1 && n < 50) begin
      @(posedge clk); #1 n++;
    end
    check("b2b_first_latency", 64'(n), 64'(LAT));
`ifdef ADD_SUBT_SAT_EN
    exp_q.push_back({1'b1, 32'h8000_0000});
`else
    exp_q.push_back({1'b1, 32'h7FFF_FFFF});
`endif
    @(negedge clk);
    Data_X = 32'h8000_0000; Data_Y = 32'h0000_0001; operation = 1'b1;
    beg_add_subt = 1'b1; ack_add_subt = 1'b1;
    @(posedge clk); #1 ack_add_subt = 1'b0;
    check("b2b_ack_wins", 64'(ready_add_subt), 64'd0);
    @(posedge clk); #1 beg_add_subt = 1'b0;
    n = 0;
    while (ready_add_subt !== 1'b1 && n < 50) begin
      @(posedge clk); #1 n++;
    end
    check("b2b_second_latency", 64'(n), 64'(LAT));
    @(negedge clk); ack_add_subt = 1'b1;
    @(posedge clk); #1 ack_add_subt = 1'b0;
    check("b2b_final_drop", 64'(ready_add_subt), 64'd0);

    repeat (3) @(posedge clk);
    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
